// File: rtl/snoop_req_ctrl.sv
// Line-fill requester for the local cache. It asks the peer cache first and falls
// back to unified memory with a bounded wait; the filled line goes back to the local cache.
module snoop_req_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req,
  input  logic [10:0] miss_addr,
  output logic        snoop_search,
  output logic [10:0] snoop_addr,
  input  logic        snoop_found,
  input  logic [63:0] snoop_line,
  output logic        mem_re,
  output logic [10:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [63:0] mem_rd_data,
  output logic        fill_valid,
  output logic [63:0] fill_data,
  output logic        fill_src,
  output logic        fill_err,
  output logic        busy,
  output logic [15:0] snoop_hits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNOOP,
    S_MEM_WAIT,
    S_DONE
  } state_e;

  // Value of the wait counter in the last MEM_WAIT cycle that is allowed to see mem_rdy.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [10:0] addr_q;
  logic [7:0]  wait_cnt_q;
  logic        snoop_search_q;
  logic        mem_re_q;
  logic        fill_valid_q;
  logic [63:0] fill_data_q;
  logic        fill_src_q;
  logic        fill_err_q;
  logic        busy_q;
  logic [15:0] snoop_hits_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values that were current before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wait_cnt_q     <= '0;
      snoop_search_q <= 1'b0;
      mem_re_q       <= 1'b0;
      fill_valid_q   <= 1'b0;
      fill_data_q    <= '0;
      fill_src_q     <= 1'b0;
      fill_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      snoop_hits_q   <= '0;
    end else begin
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (miss_req) begin
            addr_q         <= miss_addr;
            snoop_search_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          snoop_search_q <= 1'b0;
          if (!miss_req) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (snoop_found) begin
            fill_data_q  <= snoop_line;
            fill_src_q   <= 1'b1;
            fill_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            mem_re_q   <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          // A withdrawn request wins; a ready response wins over the timeout.
          if (!miss_req) begin
            mem_re_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (mem_rdy) begin
            fill_data_q  <= mem_rd_data;
            fill_src_q   <= 1'b0;
            fill_valid_q <= 1'b1;
            mem_re_q     <= 1'b0;
            state_q      <= S_DONE;
          end else if (wait_cnt_q == LAST_WAIT) begin
            fill_err_q <= 1'b1;
            mem_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          if (fill_src_q && (snoop_hits_q != 16'hFFFF)) begin
            snoop_hits_q <= snoop_hits_q + 16'd1;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign snoop_search = snoop_search_q;
  assign snoop_addr   = addr_q;
  assign mem_re       = mem_re_q;
  assign mem_addr     = addr_q;
  assign fill_valid   = fill_valid_q;
  assign fill_data    = fill_data_q;
  assign fill_src     = fill_src_q;
  assign fill_err     = fill_err_q;
  assign busy         = busy_q;
  assign snoop_hits   = snoop_hits_q;

endmodule

// File: doc/snoop_req_ctrl.md
SNOOP_REQ_CTRL -- requirements
Module: snoop_req_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 63, is the maximum MEM_WAIT cycles before abort (range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 miss_req  input  1  local cache controller requests a line fill; held high until fill_valid or abort.
REQ-005 miss_addr  input  11  line address of the miss; {tag[4:0], index[5:0]}.
REQ-006 snoop_search  output  1  search strobe to peer cache (peer cpu_search).
REQ-007 snoop_addr  output  11  line address presented to peer cache (peer BOCI).
REQ-008 snoop_found  input  1  peer reports a valid line at snoop_addr, valid while clk high in the strobe cycle.
REQ-009 snoop_line  input  64  peer line data (4 x 16-bit words), valid with snoop_found.
REQ-010 mem_re  output  1  read request to unified memory.
REQ-011 mem_addr  output  11  line address to memory.
REQ-012 mem_rdy  input  1  memory read data valid.
REQ-013 mem_rd_data  input  64  memory line data, valid with mem_rdy.
REQ-014 fill_valid  output  1  one-cycle pulse; fill_data is valid.
REQ-015 fill_data  output  64  line returned to local cache.
REQ-016 fill_src  output  1  1 = line from peer cache, 0 = from memory; valid with fill_valid.
REQ-017 fill_err  output  1  one-cycle pulse on memory timeout.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 snoop_hits  output  16  saturating count of fills sourced from peer.

Function
REQ-020 FSM states: IDLE, SNOOP, MEM_WAIT, DONE; all outputs registered.
REQ-021 IDLE: on miss_req=1, latch miss_addr into addr_q, go to SNOOP next edge; otherwise stay.
REQ-022 SNOOP: snoop_search=1 and snoop_addr=addr_q for exactly one cycle; on the ending edge sample snoop_found and snoop_line.
REQ-023 SNOOP exit: snoop_found=1 -> capture snoop_line into fill_data, fill_src=1, go to DONE; snoop_found=0 -> go to MEM_WAIT.
REQ-024 Peer tag is not checked here; snoop_found alone selects the peer source.
REQ-025 MEM_WAIT: mem_re=1, mem_addr=addr_q, wait counter increments each cycle from 0.
REQ-026 MEM_WAIT with mem_rdy=1: capture mem_rd_data into fill_data, fill_src=0, go to DONE; mem_rdy in the first MEM_WAIT cycle is accepted (minimum fill latency 3 cycles after miss_req sampled).
REQ-027 MEM_WAIT timeout: counter reaching MEM_TIMEOUT with mem_rdy=0 -> fill_err=1 one cycle, mem_re drops, go to IDLE, no fill_valid.
REQ-028 Same-cycle mem_rdy and timeout: mem_rdy wins, normal fill.
REQ-029 DONE: fill_valid=1 one cycle; snoop_hits increments if fill_src=1, saturating at 16'hFFFF; go to IDLE.
REQ-030 Peer-hit latency: fill_valid asserted 2 cycles after the edge sampling miss_req.
REQ-031 Abort: miss_req=0 observed in SNOOP or MEM_WAIT -> go to IDLE next edge, no fill_valid, no fill_err, counter unchanged.
REQ-032 miss_addr changes after latch are ignored until return to IDLE.
REQ-033 snoop_search and mem_re never high in the same cycle.
REQ-034 fill_data holds its last value outside DONE; fill_src holds last value.
REQ-035 Back-to-back: miss_req high in the cycle after DONE starts a new request from IDLE (one idle cycle minimum).

Reset
REQ-036 rst_n=0 forces IDLE immediately regardless of clk; snoop_search, mem_re, fill_valid, fill_err, busy = 0; fill_src = 0; fill_data = 64'h0; snoop_hits = 16'h0; wait counter = 0.
REQ-037 Reset mid-MEM_WAIT drops mem_re asynchronously; a later mem_rdy while in IDLE is ignored.

Verification
REQ-038 Peer hit: miss_addr=11'h2A5, snoop_found=1, snoop_line=64'h1111_2222_3333_4444 -> snoop_addr=11'h2A5 one cycle, fill_valid 2 cycles after, fill_data matches, fill_src=1, snoop_hits=1, mem_re never high.
REQ-039 Peer miss, memory in 4 cycles: snoop_found=0, mem_rdy on 4th MEM_WAIT cycle with 64'hDEAD_BEEF_0123_4567 -> mem_addr=miss_addr, fill_src=0, fill_valid once, snoop_hits unchanged.
REQ-040 Timeout with MEM_TIMEOUT=8: mem_rdy held 0 -> fill_err one cycle after 8 MEM_WAIT cycles, no fill_valid, busy=0 afterwards.
REQ-041 Abort: miss_req dropped during 2nd MEM_WAIT cycle -> IDLE next edge, mem_re=0, no fill_valid/fill_err; mem_rdy pulse after that ignored.
REQ-042 Async reset during MEM_WAIT mid-cycle -> outputs zero before next clk edge; next miss_req starts cleanly at SNOOP.
REQ-043 Saturation: preload snoop_hits via 65536 peer-hit fills (or forced) -> remains 16'hFFFF on next peer hit.
